// File: rtl/dp_controller.sv
// dp_controller: sequences one data-processing instruction per request
// through IDLE -> LOAD -> EXEC -> WB and drives the register-file, shifter,
// ALU and status-flag controls of the datapath.
// Latency: start accepted at edge N, done pulses in the WB cycle (N+3), and
// ready returns in the cycle after that.
// Backpressure: start is only sampled while ready=1; requests made while the
// controller is busy are dropped, not queued.
//
// Ports:
//   clk, rst_n        : clock and asynchronous active-low reset
//   start, instr      : request and the 32-bit instruction word it carries
//   ready, done       : idle indication and end-of-instruction pulse
//   illegal           : pulses with done for an unsupported instruction
//   w_addr, w_en      : register-file write port (WB only)
//   A_addr, B_addr,
//   shift_addr        : register-file read addresses (held from LOAD to WB)
//   en_A, en_B, en_S  : operand-latch enables (LOAD only)
//   shift_op, shift_imme, sel_shift : shifter control
//   sel_A, sel_B, imme_data         : operand muxes and immediate value
//   ALU_op, en_status, wb_sel       : ALU function, flag update, WB source
//
// Build option: define DP_CTRL_REG_SHIFT_EN to support shifts whose amount
// comes from a register (I=0, instr[4]=1). Without it such instructions are
// reported as illegal and sel_shift stays 0.

module dp_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instr,
  output logic        ready,
  output logic        done,
  output logic        illegal,
  output logic [3:0]  w_addr,
  output logic        w_en,
  output logic [3:0]  A_addr,
  output logic [3:0]  B_addr,
  output logic [3:0]  shift_addr,
  output logic        en_A,
  output logic        en_B,
  output logic        en_S,
  output logic [1:0]  shift_op,
  output logic [31:0] shift_imme,
  output logic        sel_shift,
  output logic        sel_A,
  output logic        sel_B,
  output logic [31:0] imme_data,
  output logic [2:0]  ALU_op,
  output logic        en_status,
  output logic        wb_sel
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;

  // ---------------------------------------------------------------------
  // Sequencer: the only decision is in IDLE; every other state advances
  // unconditionally, so an accepted instruction always takes four cycles.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          instr_d = instr;
        end
      end
      S_LOAD:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // ---------------------------------------------------------------------
  // Decode of the captured word. Never looks at the live instr input.
  // ---------------------------------------------------------------------
  logic [3:0] opcode;
  logic       i_bit;
  logic       s_bit;
  logic       reg_shift;
  logic       op_legal;
  logic       is_cmp;
  logic       is_mov;
  logic [2:0] alu_dec;
  logic       shift_legal;
  logic       sel_shift_dec;
  logic       illegal_dec;

  assign opcode    = instr_q[24:21];
  assign i_bit     = instr_q[25];
  assign s_bit     = instr_q[20];
  assign reg_shift = !i_bit && instr_q[4];

  always_comb begin
    op_legal = 1'b1;
    is_cmp   = 1'b0;
    is_mov   = 1'b0;
    alu_dec  = 3'b000;
    case (opcode)
      4'b0000: alu_dec = 3'b010;                 // AND
      4'b0001: alu_dec = 3'b100;                 // EOR
      4'b0010: alu_dec = 3'b001;                 // SUB
      4'b0100: alu_dec = 3'b000;                 // ADD
      4'b1100: alu_dec = 3'b011;                 // ORR
      4'b1101: begin                             // MOV: A side forced by sel_A
        alu_dec = 3'b000;
        is_mov  = 1'b1;
      end
      4'b1010: begin                             // CMP: subtract, flags only
        alu_dec = 3'b001;
        is_cmp  = 1'b1;
      end
      default: op_legal = 1'b0;
    endcase
  end

`ifdef DP_CTRL_REG_SHIFT_EN
  assign shift_legal   = 1'b1;
  assign sel_shift_dec = reg_shift;
`else
  // No register-amount shifter in this build: reject those encodings.
  assign shift_legal   = !reg_shift;
  assign sel_shift_dec = 1'b0;
`endif

  assign illegal_dec = !op_legal || !shift_legal;

  // ---------------------------------------------------------------------
  // Outputs. Operand/shift/ALU selects are held for the whole LOAD..WB
  // window so the datapath sees one steady configuration per instruction;
  // the enables and pulses are confined to their own state.
  // ---------------------------------------------------------------------
  always_comb begin
    ready      = (state_q == S_IDLE);
    done       = 1'b0;
    illegal    = 1'b0;
    w_addr     = 4'd0;
    w_en       = 1'b0;
    A_addr     = 4'd0;
    B_addr     = 4'd0;
    shift_addr = 4'd0;
    en_A       = 1'b0;
    en_B       = 1'b0;
    en_S       = 1'b0;
    shift_op   = 2'd0;
    shift_imme = 32'd0;
    sel_shift  = 1'b0;
    sel_A      = 1'b0;
    sel_B      = 1'b0;
    imme_data  = 32'd0;
    ALU_op     = 3'd0;
    en_status  = 1'b0;
    wb_sel     = 1'b0;

    if (state_q != S_IDLE) begin
      A_addr     = instr_q[19:16];
      B_addr     = instr_q[3:0];
      shift_addr = instr_q[11:8];
      shift_op   = instr_q[6:5];
      shift_imme = {27'd0, instr_q[11:7]};
      sel_shift  = sel_shift_dec;
      sel_A      = is_mov;
      sel_B      = i_bit;
      imme_data  = i_bit ? {20'd0, instr_q[11:0]} : 32'd0;
      ALU_op     = alu_dec;
    end

    if (state_q == S_LOAD) begin
      en_A = 1'b1;
      en_B = 1'b1;
      en_S = 1'b1;
    end

    if (state_q == S_WB) begin
      done      = 1'b1;
      illegal   = illegal_dec;
      w_addr    = instr_q[15:12];
      w_en      = !illegal_dec && !is_cmp;
      en_status = !illegal_dec && (s_bit || is_cmp);
    end
  end

endmodule

// File: tb/tb_dp_controller.sv
module tb_dp_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] instr;
  logic        ready, done, illegal, w_en, en_A, en_B, en_S;
  logic        sel_shift, sel_A, sel_B, en_status, wb_sel;
  logic [3:0]  w_addr, A_addr, B_addr, shift_addr;
  logic [1:0]  shift_op;
  logic [31:0] shift_imme, imme_data;
  logic [2:0]  ALU_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dp_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
    .ready(ready), .done(done), .illegal(illegal),
    .w_addr(w_addr), .w_en(w_en),
    .A_addr(A_addr), .B_addr(B_addr), .shift_addr(shift_addr),
    .en_A(en_A), .en_B(en_B), .en_S(en_S),
    .shift_op(shift_op), .shift_imme(shift_imme), .sel_shift(sel_shift),
    .sel_A(sel_A), .sel_B(sel_B), .imme_data(imme_data),
    .ALU_op(ALU_op), .en_status(en_status), .wb_sel(wb_sel)
  );

  typedef struct packed {
    logic        ready, done, illegal;
    logic [3:0]  w_addr;
    logic        w_en;
    logic [3:0]  a_addr, b_addr, shift_addr;
    logic        en_a, en_b, en_s;
    logic [1:0]  shift_op;
    logic [31:0] shift_imme;
    logic        sel_shift, sel_a, sel_b;
    logic [31:0] imme_data;
    logic [2:0]  alu_op;
    logic        en_status, wb_sel;
  } outs_t;

  // Reference model: "age" is how many cycles ago the current instruction
  // was accepted (0 = nothing in flight), "word" is the accepted instruction.
  int          age  = 0;
  logic [31:0] word = 32'd0;
  bit          cmp_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age  <= 0;
      word <= 32'd0;
    end else if (age == 0) begin
      if (start) begin
        age  <= 1;
        word <= instr;
      end
    end else begin
      age <= (age + 1) % 4;
    end
  end

  function automatic outs_t expect_of(input int a, input logic [31:0] w);
    outs_t      o;
    logic [3:0] op;
    bit         known;
    bit         bad;
    bit         regsh;
    o  = '0;
    op = w[24:21];
    if (a == 0) begin
      o.ready = 1'b1;
      return o;
    end
    known = 1'b1;
    if      (op == 4'd0)  o.alu_op = 3'd2;
    else if (op == 4'd1)  o.alu_op = 3'd4;
    else if (op == 4'd2)  o.alu_op = 3'd1;
    else if (op == 4'd4)  o.alu_op = 3'd0;
    else if (op == 4'd12) o.alu_op = 3'd3;
    else if (op == 4'd13) o.alu_op = 3'd0;
    else if (op == 4'd10) o.alu_op = 3'd1;
    else                  known = 1'b0;
    regsh = (w[25] == 1'b0) && (w[4] == 1'b1);
`ifdef DP_CTRL_REG_SHIFT_EN
    bad         = !known;
    o.sel_shift = regsh;
`else
    bad         = !known || regsh;
    o.sel_shift = 1'b0;
`endif
    o.a_addr     = w[19:16];
    o.b_addr     = w[3:0];
    o.shift_addr = w[11:8];
    o.shift_op   = w[6:5];
    o.shift_imme = 32'(w[11:7]);
    o.sel_a      = (op == 4'd13);
    o.sel_b      = w[25];
    o.imme_data  = w[25] ? 32'(w[11:0]) : 32'd0;
    if (a == 1) begin
      o.en_a = 1'b1;
      o.en_b = 1'b1;
      o.en_s = 1'b1;
    end
    if (a == 3) begin
      o.done      = 1'b1;
      o.illegal   = bad;
      o.w_addr    = w[15:12];
      o.w_en      = !bad && (op != 4'd10);
      o.en_status = !bad && (w[20] || op == 4'd10);
    end
    return o;
  endfunction

  outs_t act_o, exp_o;
  always_comb begin
    act_o = {ready, done, illegal, w_addr, w_en, A_addr, B_addr, shift_addr,
             en_A, en_B, en_S, shift_op, shift_imme, sel_shift, sel_A, sel_B,
             imme_data, ALU_op, en_status, wb_sel};
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      exp_o = expect_of(age, word);
      checks++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL cycle_model t=%0t age=%0d got %h expected %h",
                 $time, age, act_o, exp_o);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at posedge+2 while idle; returns at posedge+2 in LOAD with the
  // input word scrambled so only the captured copy can be used.
  task automatic issue(input logic [31:0] w);
    start = 1'b1;
    instr = w;
    @(posedge clk); #2;
    start = 1'b0;
    instr = 32'hFFFF_FFFF;
  endtask

  task automatic sync();
    @(posedge clk); #2;
  endtask

  localparam logic [31:0] ADD_I = 32'h0281_3005;
  localparam logic [31:0] CMP_R = 32'h0152_0004;
  localparam logic [31:0] ORR_S = 32'h0181_0512;
  localparam logic [31:0] BAD_7 = 32'h00E0_7000;
  localparam logic [31:0] MOV_I = 32'h03A0_80AB;

  logic [31:0] table_w [5];

  initial begin
    table_w[0] = 32'h0015_4006;   // ANDS R4,R5,R6
    table_w[1] = 32'h0222_90FF;   // EOR R9,R2,#0xFF
    table_w[2] = 32'h0043_11C7;   // SUB R1,R3,R7 ASR #3
    table_w[3] = MOV_I;           // MOV R8,#0xAB
    table_w[4] = 32'h03E0_1001;   // opcode 1111 with immediate: illegal

    rst_n = 1'b1;
    start = 1'b0;
    instr = 32'd0;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sync();

    // Reset state
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_en_A", 32'(en_A), 32'd0);
    chk("rst_w_en", 32'(w_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_alu_op", 32'(ALU_op), 32'd0);

    // ADD R3,R1,#5
    issue(ADD_I);
    @(negedge clk);
    chk("add_load_en_A", 32'(en_A), 32'd1);
    chk("add_load_en_B", 32'(en_B), 32'd1);
    chk("add_load_en_S", 32'(en_S), 32'd1);
    chk("add_load_ready", 32'(ready), 32'd0);
    chk("add_load_imme", imme_data, 32'd5);
    @(negedge clk);
    chk("add_exec_sel_B", 32'(sel_B), 32'd1);
    @(negedge clk);
    chk("add_wb_w_en", 32'(w_en), 32'd1);
    chk("add_wb_w_addr", 32'(w_addr), 32'd3);
    chk("add_wb_done", 32'(done), 32'd1);
    chk("add_wb_imme", imme_data, 32'd5);
    @(negedge clk);
    chk("add_ready_back", 32'(ready), 32'd1);
    sync();

    // CMP R2,R4
    issue(CMP_R);
    @(negedge clk);
    chk("cmp_alu_op", 32'(ALU_op), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("cmp_wb_w_en", 32'(w_en), 32'd0);
    chk("cmp_wb_en_status", 32'(en_status), 32'd1);
    chk("cmp_wb_done", 32'(done), 32'd1);
    sync();

    // ORR R0,R1,R2 LSL R5
    issue(ORR_S);
    @(negedge clk);
    chk("orr_shift_addr", 32'(shift_addr), 32'd5);
    chk("orr_shift_op", 32'(shift_op), 32'd0);
    chk("orr_shift_imme", shift_imme, 32'd10);
`ifdef DP_CTRL_REG_SHIFT_EN
    chk("orr_sel_shift", 32'(sel_shift), 32'd1);
`else
    chk("orr_sel_shift", 32'(sel_shift), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
`ifdef DP_CTRL_REG_SHIFT_EN
    chk("orr_illegal", 32'(illegal), 32'd0);
    chk("orr_w_en", 32'(w_en), 32'd1);
`else
    chk("orr_illegal", 32'(illegal), 32'd1);
    chk("orr_w_en", 32'(w_en), 32'd0);
`endif
    chk("orr_done", 32'(done), 32'd1);
    sync();

    // start held high; instr changes to opcode 0111 while ADD is in flight
    start = 1'b1;
    instr = ADD_I;
    @(posedge clk); #2;
    instr = BAD_7;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_first_w_addr", 32'(w_addr), 32'd3);
    chk("b2b_first_w_en", 32'(w_en), 32'd1);
    chk("b2b_first_illegal", 32'(illegal), 32'd0);
    @(posedge clk);
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_second_A_addr", 32'(A_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_second_illegal", 32'(illegal), 32'd1);
    chk("b2b_second_done", 32'(done), 32'd1);
    chk("b2b_second_w_en", 32'(w_en), 32'd0);
    sync();

    // Reset pulse during EXEC
    issue(ADD_I);
    sync();
    rst_n = 1'b0;
    #1;
    chk("rstx_ready", 32'(ready), 32'd1);
    chk("rstx_w_en", 32'(w_en), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rstx_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rstx_no_wb", 32'({done, w_en, en_status}), 32'd0);
    end
    sync();

    // Remaining opcodes; checked cycle by cycle by the model
    for (int k = 0; k < 5; k++) begin
      issue(table_w[k]);
      if (k == 2) begin
        @(negedge clk);
        chk("sub_shift_imme", shift_imme, 32'd3);
        chk("sub_shift_op", 32'(shift_op), 32'd2);
      end
      if (k == 3) begin
        @(negedge clk);
        chk("mov_sel_A", 32'(sel_A), 32'd1);
        chk("mov_imme", imme_data, 32'hAB);
      end
      repeat (3) @(posedge clk);
      #2;
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
